// File: rtl/input_port_if.sv
// Peripheral bus shared by the memory-mapped I/O blocks: active-low chip select,
// write enable, 11-bit address, 32-bit write data and registered read data.
interface input_port_if;
  logic        nce;
  logic        we;
  logic [10:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output nce, output we, output addr, output wdata, input rdata);
  modport slave  (input nce, input we, input addr, input wdata, output rdata);
endinterface

// File: rtl/input_port_module.sv
// Memory-mapped parallel input port: synchronized, debounced pins, sticky W1C
// rising-edge flags, per-bit interrupt mask and a level interrupt.
module input_port_module #(
  parameter int WIDTH           = 10,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input_port_if.slave      bus,
  input  logic [WIDTH-1:0] pin_in,
  output logic             irq
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [10:0] {
    REG_LEVEL = 11'd0,
    REG_EDGE  = 11'd1,
    REG_MASK  = 11'd2
  } reg_addr_e;

  logic [WIDTH-1:0] sync1, sync2;
  logic [WIDTH-1:0] stable, stable_next;
  logic [WIDTH-1:0] edge_flags, mask;
  logic [CW-1:0]    cnt      [WIDTH];
  logic [CW-1:0]    cnt_next [WIDTH];
  logic             rd_strobe, wr_strobe;
  logic [WIDTH-1:0] w1c;
  logic [31:0]      rd_sel;
  logic             wdata_unused;

  assign rd_strobe    = !bus.nce && !bus.we;
  assign wr_strobe    = !bus.nce &&  bus.we;
  assign wdata_unused = ^bus.wdata[31:WIDTH];

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned and a latch is inferred.
  always_comb begin
    stable_next = stable;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_next[i] = '0;
      if (sync2[i] != stable[i]) begin
        if (cnt[i] == CNT_LAST) stable_next[i] = sync2[i];
        else                    cnt_next[i]    = cnt[i] + CW'(1);
      end
    end
  end

  always_comb begin
    w1c    = (wr_strobe && bus.addr == REG_EDGE) ? bus.wdata[WIDTH-1:0] : '0;
    rd_sel = '0;
    case (bus.addr)
      REG_LEVEL: rd_sel = 32'(stable);
      REG_EDGE:  rd_sel = 32'(edge_flags);
      REG_MASK:  rd_sel = 32'(mask);
      default:   rd_sel = '0;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values, which is what makes reads return the register as it stood before the strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1      <= '0;
      sync2      <= '0;
      stable     <= '0;
      edge_flags <= '0;
      mask       <= '0;
      bus.rdata  <= '0;
      // NOTE: the debounce counters are ordinary flops and are cleared too, so a reset mid-debounce restarts the count.
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      sync1  <= pin_in;
      sync2  <= sync1;
      stable <= stable_next;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= cnt_next[i];
      // A rising edge in the same cycle as its W1C clear keeps the flag set.
      edge_flags <= (edge_flags & ~w1c) | (stable_next & ~stable);
      if (wr_strobe && bus.addr == REG_MASK) mask <= bus.wdata[WIDTH-1:0];
      bus.rdata <= rd_strobe ? rd_sel : '0;
    end
  end

  assign irq = |(edge_flags & mask);

endmodule
